// File: rtl/decomposable_right_shifter.sv
// Registered 32-bit right shifter that splits into 1x32, 2x16 or 4x8 independent lanes,
// each lane with its own shift amount and its own fill bit.
module decomposable_right_shifter #(
    parameter int unsigned ARITH_SHIFT        = 1,
    parameter logic        EXTENSION_BIT      = 1'b0,
    parameter int unsigned PRECISION_CONFIG_L = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   in,
    input  logic [19:0]                   shift_val,
    input  logic                          full_shift,
    input  logic [PRECISION_CONFIG_L-1:0] mode,
    output logic [31:0]                   out
);

    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = PRECISION_CONFIG_L'(0);
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = PRECISION_CONFIG_L'(1);
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = PRECISION_CONFIG_L'(2);

    logic        is_8b_s;
    logic        is_16b_s;
    logic [4:0]  bit_amt_s [32];
    logic [5:0]  bit_top_s [32];
    logic [31:0] bit_fill_s;
    logic [31:0] bit_sat_s;
    logic [31:0] stage_s [6];
    logic [31:0] out_d;
    logic [31:0] out_q;

    // Lane configuration decode; the reserved encoding falls back to a single 32-bit lane.
    always_comb begin
        is_8b_s  = 1'b0;
        is_16b_s = 1'b0;
        case (mode)
            PRECISION_CONFIG_8B:  is_8b_s  = 1'b1;
            PRECISION_CONFIG_16B: is_16b_s = 1'b1;
            PRECISION_CONFIG_32B: is_8b_s  = 1'b0;
            default:              is_8b_s  = 1'b0;
        endcase
    end

    // Per-bit view of the owning lane: its top bit index, shift amount, fill bit and saturation.
    always_comb begin
        bit_fill_s = 32'h0000_0000;
        bit_sat_s  = 32'h0000_0000;
        for (int i = 0; i < 32; i++) begin
            bit_amt_s[i] = 5'd0;
            bit_top_s[i] = 6'd31;
            if (is_8b_s) begin
                bit_top_s[i] = 6'(((i / 8) * 8) + 7);
                bit_amt_s[i] = shift_val[5 * (i / 8) +: 5];
                bit_sat_s[i] = (shift_val[(5 * (i / 8)) + 3 +: 2] != 2'b00);
            end else if (is_16b_s) begin
                // 16-bit lane 1 takes its amount from slot 2, so slots are 10 bits apart
                bit_top_s[i] = 6'(((i / 16) * 16) + 15);
                bit_amt_s[i] = shift_val[10 * (i / 16) +: 5];
                bit_sat_s[i] = shift_val[(10 * (i / 16)) + 4];
            end else begin
                bit_top_s[i] = 6'd31;
                bit_amt_s[i] = shift_val[4:0];
                bit_sat_s[i] = 1'b0;
            end
            if (ARITH_SHIFT != 0) begin
                bit_fill_s[i] = in[bit_top_s[i][4:0]];
            end else begin
                bit_fill_s[i] = EXTENSION_BIT;
            end
        end
    end

    // Log shifter: a source bit outside the destination's lane is replaced by that lane's fill.
    always_comb begin
        stage_s    = '{default: 32'h0000_0000};
        stage_s[0] = in;
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 32; i++) begin
                if (bit_amt_s[i][s]) begin
                    if ((i + (1 << s)) <= int'(bit_top_s[i])) begin
                        stage_s[s + 1][i] = stage_s[s][(i + (1 << s)) & 31];
                    end else begin
                        stage_s[s + 1][i] = bit_fill_s[i];
                    end
                end else begin
                    stage_s[s + 1][i] = stage_s[s][i];
                end
            end
        end
    end

    // Saturating amounts and full_shift flood the lane with its fill bit.
    always_comb begin
        out_d = 32'h0000_0000;
        for (int i = 0; i < 32; i++) begin
            if (full_shift || bit_sat_s[i]) begin
                out_d[i] = bit_fill_s[i];
            end else begin
                out_d[i] = stage_s[5][i];
            end
        end
    end

    // Output register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= 32'h0000_0000;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_decomposable_right_shifter.sv
// Bench for decomposable_right_shifter: arithmetic, logical/0 and logical/1 variants share the
// same stimulus and are checked against a lane-level arithmetic model plus literal vectors.
module tb_decomposable_right_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] tb_in = 32'h0;
    logic [19:0] tb_sv = 20'h0;
    logic        tb_fs = 1'b0;
    logic [1:0]  tb_mode = 2'd0;
    logic [31:0] out_a, out_l0, out_l1;
    bit          check_en = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    decomposable_right_shifter #(.ARITH_SHIFT(1), .EXTENSION_BIT(1'b0), .PRECISION_CONFIG_L(2)) u_arith (
        .clk(clk), .rst(rst), .in(tb_in), .shift_val(tb_sv), .full_shift(tb_fs), .mode(tb_mode), .out(out_a));
    decomposable_right_shifter #(.ARITH_SHIFT(0), .EXTENSION_BIT(1'b0), .PRECISION_CONFIG_L(2)) u_log0 (
        .clk(clk), .rst(rst), .in(tb_in), .shift_val(tb_sv), .full_shift(tb_fs), .mode(tb_mode), .out(out_l0));
    decomposable_right_shifter #(.ARITH_SHIFT(0), .EXTENSION_BIT(1'b1), .PRECISION_CONFIG_L(2)) u_log1 (
        .clk(clk), .rst(rst), .in(tb_in), .shift_val(tb_sv), .full_shift(tb_fs), .mode(tb_mode), .out(out_l1));

    // Lane-by-lane reference using plain integer shifts and masks.
    function automatic logic [31:0] model(logic [31:0] d, logic [19:0] sv, logic fs, logic [1:0] md,
                                          bit arith, bit ext);
        logic [31:0] r;
        int w;
        r = 32'h0;
        w = (md == 2'd2) ? 8 : ((md == 2'd1) ? 16 : 32);
        for (int l = 0; l < 32 / w; l++) begin
            longint unsigned v, mask, res;
            int a;
            bit f;
            mask = (64'd1 << w) - 64'd1;
            v    = (64'(d) >> (l * w)) & mask;
            if (w == 8)       a = int'(sv[5 * l +: 5]);
            else if (w == 16) a = int'(sv[10 * l +: 5]);
            else              a = int'(sv[4:0]);
            f = arith ? bit'((v >> (w - 1)) & 64'd1) : ext;
            if (fs || a >= w) begin
                res = f ? mask : 64'd0;
            end else begin
                res = v >> a;
                if (f) res = res | (mask & ~(mask >> a));
            end
            r = r | (32'(res) << (l * w));
        end
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every clock edge out of reset: predict from the inputs sampled at the edge, compare just after.
    always @(posedge clk) begin
        logic [31:0] e_a, e_0, e_1;
        if (check_en && rst) begin
            e_a = model(tb_in, tb_sv, tb_fs, tb_mode, 1'b1, 1'b0);
            e_0 = model(tb_in, tb_sv, tb_fs, tb_mode, 1'b0, 1'b0);
            e_1 = model(tb_in, tb_sv, tb_fs, tb_mode, 1'b0, 1'b1);
            #1;
            check("model_arith", out_a, e_a);
            check("model_log0", out_l0, e_0);
            check("model_log1", out_l1, e_1);
        end
    end

    task automatic apply(logic [31:0] d, logic [19:0] sv, logic fs, logic [1:0] md);
        tb_in   = d;
        tb_sv   = sv;
        tb_fs   = fs;
        tb_mode = md;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #3;
        check("reset_arith", out_a, 32'h0);
        check("reset_log1", out_l1, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        check_en = 1'b1;

        apply(32'h7070_7070, {5'd31, 5'd1, 5'd2, 5'd0, 5'd3}, 1'b0, 2'd2);
        check("lit_8b_arith", out_a, 32'h381C_700E);
        check("lit_8b_log1", out_l1, 32'hB8DC_70EE);

        apply(32'h8000_0000, {5'd31, 5'd31, 5'd31, 5'd4}, 1'b0, 2'd0);
        check("lit_32b_arith", out_a, 32'hF800_0000);
        check("lit_32b_log0", out_l0, 32'h0800_0000);
        check("lit_32b_log1", out_l1, 32'hF800_0000);

        apply(32'h8000_0000, {5'd31, 5'd31, 5'd31, 5'd4}, 1'b0, 2'd3);
        check("lit_mode3_arith", out_a, 32'hF800_0000);

        apply(32'h8000_4000, {5'd31, 5'd15, 5'd31, 5'd2}, 1'b0, 2'd1);
        check("lit_16b_arith", out_a, 32'hFFFF_1000);

        apply(32'h807F_807F, {5'd9, 5'd9, 5'd9, 5'd9}, 1'b0, 2'd2);
        check("lit_sat_arith", out_a, 32'hFF00_FF00);

        apply(32'h807F_807F, 20'h0, 1'b1, 2'd2);
        check("lit_full_arith", out_a, 32'hFF00_FF00);
        check("lit_full_log0", out_l0, 32'h0000_0000);

        apply(32'h1234_5678, 20'h0, 1'b0, 2'd0);
        check("lit_pass_arith", out_a, 32'h1234_5678);

        // Asynchronous reset between edges
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_arith", out_a, 32'h0);
        check("async_rst_log1", out_l1, 32'h0);
        apply(32'hFFFF_FFFF, 20'h0, 1'b0, 2'd0);
        check("rst_hold_arith", out_a, 32'h0);
        rst = 1'b1;
        apply(32'h0000_00F0, 20'd4, 1'b0, 2'd0);
        check("post_rst_arith", out_a, 32'h0000_000F);

        // Random back-to-back traffic, mostly alternating 8B/32B
        for (int c = 0; c < 300; c++) begin
            logic [1:0]  md;
            logic [19:0] sv;
            md = (c % 2 == 0) ? 2'd2 : 2'd0;
            if (c >= 200) md = 2'($urandom_range(0, 3));
            sv = 20'($urandom);
            if ($urandom_range(0, 3) == 0) sv = 20'h0;
            apply(32'($urandom), sv, ($urandom_range(0, 15) == 0), md);
        end

        check_en = 1'b0;
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
